// File: rtl/hub_div_seq.sv
// rtl/hub_div_seq.sv - Sequential restoring radix-2 HUB floating-point divider
//
// Computes Z = X / Y on {sign, E-bit exponent (bias 2^(E-1)), M-bit mantissa} operands.
// The significand is {1, mantissa, 1}: implicit leading one plus implicit ILSB.
// One quotient bit is produced per CALC cycle. HUB truncation gives round-to-nearest.
//
// Ports:
//   clk        single clock, all state on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   X/Y valid
//   in_ready   block can accept X/Y (IDLE only, low while in reset)
//   X, Y       dividend and divisor
//   out_valid  Z valid (DONE only)
//   out_ready  consumer takes Z
//   Z          registered quotient, held while out_valid & !out_ready
`timescale 1ns/1ps
module hub_div_seq #(
    parameter int M = 23,
    parameter int E = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [E+M:0] X,
    input  logic [E+M:0] Y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [E+M:0] Z
);
    localparam int W  = E + M + 1;
    localparam int RW = M + 3;
    localparam int CW = $clog2(M + 3);
    localparam logic [E+1:0] BIAS  = (E+2)'(1 << (E - 1));
    localparam logic [E+1:0] E_OVF = (E+2)'((1 << E) - 1);

    typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [RW-1:0] rem;
    logic [M+1:0]  dy;
    logic [RW-1:0] q;
    logic [CW-1:0] cnt;
    logic [E+1:0]  e_pre;
    logic          sgn;
    logic [W-1:0]  z_r;

    // Operand fields and classification
    logic [E-1:0] xe;
    logic [E-1:0] ye;
    logic [M-1:0] xm;
    logic [M-1:0] ym;
    logic         x_zero;
    logic         y_zero;
    logic         x_inf;
    logic         y_inf;
    logic         x_nan;
    logic         y_nan;
    logic         s_in;
    logic         special;
    logic         accept;
    logic [W-1:0] spec_z;

    assign xe     = X[W-2:M];
    assign ye     = Y[W-2:M];
    assign xm     = X[M-1:0];
    assign ym     = Y[M-1:0];
    assign x_zero = (xe == '0);
    assign y_zero = (ye == '0);
    assign x_inf  = (&xe) && (xm == '0);
    assign y_inf  = (&ye) && (ym == '0);
    assign x_nan  = (&xe) && (xm != '0);
    assign y_nan  = (&ye) && (ym != '0);
    assign s_in   = X[W-1] ^ Y[W-1];
    assign special = x_zero || y_zero || (&xe) || (&ye);

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign Z         = z_r;
    assign accept    = in_valid && in_ready;

    // Special results; NaN checks take priority, then infinities, then zeros
    always_comb begin
        spec_z = '0;
        if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
            spec_z = {1'b0, {E{1'b1}}, {M{1'b1}}};
        end else if (y_zero || x_inf) begin
            spec_z = {s_in, {E{1'b1}}, {M{1'b0}}};
        end else begin
            spec_z = {s_in, {(E+M){1'b0}}};
        end
    end

    // Restoring step: the remainder stays below dy after the subtract, so its
    // top bit is always zero and the left shift never loses information.
    logic          ge;
    logic [RW-1:0] diff;
    logic [RW-1:0] rem_sub;
    logic [RW-1:0] rem_nx;

    always_comb begin
        ge      = (rem >= {1'b0, dy});
        diff    = rem - {1'b0, dy};
        rem_sub = ge ? diff : rem;
        rem_nx  = {rem_sub[RW-2:0], 1'b0};
    end

    // Normalisation: quotient lies in [2^(M+1), 2^(M+3)), so at most one
    // position of shift is needed; the dropped tail is the HUB truncation.
    logic [M-1:0] mant;
    logic [E+1:0] e_fin;
    logic [W-1:0] norm_z;

    always_comb begin
        mant   = '0;
        e_fin  = e_pre;
        norm_z = '0;
        if (q[M+2]) begin
            mant  = q[M+1:2];
            e_fin = e_pre;
        end else begin
            mant  = q[M:1];
            e_fin = e_pre - 1'b1;
        end
        if (!e_fin[E+1] && (e_fin >= E_OVF)) begin
            norm_z = {sgn, {E{1'b1}}, {M{1'b0}}};
        end else if (e_fin[E+1] || (e_fin == '0)) begin
            norm_z = {sgn, {(E+M){1'b0}}};
        end else begin
            norm_z = {sgn, e_fin[E-1:0], mant};
        end
    end

    logic unused_bits;
    assign unused_bits = ^{q[0], rem_sub[RW-1]};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = special ? DONE : CALC;
            CALC:    if (cnt == CW'(M + 2)) state_nx = NORM;
            NORM:    state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rem   <= '0;
            dy    <= '0;
            q     <= '0;
            cnt   <= '0;
            e_pre <= '0;
            sgn   <= 1'b0;
            z_r   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sgn   <= s_in;
                        e_pre <= {2'b00, xe} - {2'b00, ye} + BIAS;
                        dy    <= {1'b1, ym, 1'b1};
                        rem   <= {2'b01, xm, 1'b1};
                        q     <= '0;
                        cnt   <= '0;
                        if (special) z_r <= spec_z;
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    q   <= {q[RW-2:0], ge};
                    cnt <= cnt + 1'b1;
                end
                NORM: z_r <= norm_z;
                default: ;
            endcase
        end
    end
endmodule
